// File: rtl/sprite_pkg.sv
// Shared widths, types and helpers for the sprite ROM arbiter.
package sprite_pkg;

   localparam int unsigned SPRITE_ADDR_W  = 15;
   localparam int unsigned SPRITE_DATA_W  = 32;
   localparam int unsigned SPRITE_NUM_REQ = 4;

   typedef logic [SPRITE_ADDR_W-1:0]           sprite_addr_t;
   typedef logic [SPRITE_DATA_W-1:0]           sprite_word_t;
   typedef logic [$clog2(SPRITE_NUM_REQ)-1:0]  req_id_t;

   // Round-robin successor of idx within [lo, n-1], wrapping n-1 -> lo.
   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned lo,
                                           input int unsigned n);
      return (idx + 1 >= n) ? lo : idx + 1;
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_picker.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr.
// SPRITE_ARB_PRIO0_EN: req[0] always wins, the rest rotate over 1..NUM_REQ-1.
module rr_priority_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   logic [31:0] start_w;
   logic [31:0] dist_w;
   logic [31:0] best_w;

   // Winner is the requester with the smallest circular distance from the start point.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any     = 1'b0;
      best_w  = NUM_REQ;
      dist_w  = '0;
      start_w = 32'(rr_ptr);
`ifdef SPRITE_ARB_PRIO0_EN
      if (start_w == 32'd0) begin
         start_w = 32'd1;
      end
      if (req[0]) begin
         any = 1'b1;
      end else begin
         for (int unsigned i = 1; i < NUM_REQ; i++) begin
            if (req[i]) begin
               dist_w = (i >= start_w) ? (i - start_w) : (i + NUM_REQ - 1 - start_w);
               if (dist_w < best_w) begin
                  best_w = dist_w;
                  idx    = ID_W'(i);
                  any    = 1'b1;
               end
            end
         end
      end
`else
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i]) begin
            dist_w = (i >= start_w) ? (i - start_w) : (i + NUM_REQ - start_w);
            if (dist_w < best_w) begin
               best_w = dist_w;
               idx    = ID_W'(i);
               any    = 1'b1;
            end
         end
      end
`endif
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of the single-port sprite ROM with ID-tagged, in-order read returns.
// SPRITE_ARB_PRIO0_EN gives requester 0 absolute priority over the round-robin group.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned ADDR_W  = SPRITE_ADDR_W,
   parameter  int unsigned DATA_W  = SPRITE_DATA_W,
   parameter  int unsigned ROM_LAT = 2,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic                      rd_valid,
   output logic [ID_W-1:0]           rd_id,
   output logic [DATA_W-1:0]         rd_data
);

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               fire;

   logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [ROM_LAT:0]   vld_q,      vld_d;
   logic [ID_W-1:0]    id_q [ROM_LAT+1];
   logic [ID_W-1:0]    id_d [ROM_LAT+1];
   logic [DATA_W-1:0]  rd_data_q,  rd_data_d;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .gnt    (pick_gnt),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign fire = pick_any & ~Reset;
   assign gnt  = Reset ? '0 : pick_gnt;

   // Stage 0 launches with rom_addr; stage ROM_LAT-1 lines up with valid rom_data.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rom_addr_d = rom_addr_q;
      if (fire) begin
         rom_addr_d = req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
`ifdef SPRITE_ARB_PRIO0_EN
         if (pick_idx != '0) begin
            rr_ptr_d = ID_W'(rr_next(32'(pick_idx), 32'd1, NUM_REQ));
         end
`else
         rr_ptr_d = ID_W'(rr_next(32'(pick_idx), 32'd0, NUM_REQ));
`endif
      end

      vld_d   = {vld_q[ROM_LAT-1:0], fire};
      id_d[0] = pick_idx;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
         id_d[k] = id_q[k-1];
      end

      rd_data_d = vld_q[ROM_LAT-1] ? rom_data : rd_data_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr_q   <= '0;
         rom_addr_q <= '0;
         vld_q      <= '0;
         rd_data_q  <= '0;
         for (int unsigned k = 0; k <= ROM_LAT; k++) begin
            id_q[k] <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rom_addr_q <= rom_addr_d;
         vld_q      <= vld_d;
         rd_data_q  <= rd_data_d;
         id_q       <= id_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rd_valid = vld_q[ROM_LAT];
   assign rd_id    = id_q[ROM_LAT];
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus randomized clients
// checked against a queue-based reference model (honours SPRITE_ARB_PRIO0_EN).
module tb_sprite_rom_arbiter;
   import sprite_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned AW  = SPRITE_ADDR_W;
   localparam int unsigned DW  = SPRITE_DATA_W;
   localparam int unsigned LAT = 2;

   logic                 Clk = 1'b0;
   logic                 Reset = 1'b1;
   logic [N-1:0]         req = '0;
   logic [N*AW-1:0]      req_addr = '0;
   logic [N-1:0]         gnt;
   sprite_addr_t         rom_addr;
   sprite_word_t         rom_data = '0;
   logic                 rd_valid;
   req_id_t              rd_id;
   sprite_word_t         rd_data;

   sprite_rom_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .ROM_LAT (LAT)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rd_valid (rd_valid),
      .rd_id    (rd_id),
      .rd_data  (rd_data)
   );

   always #5 Clk = ~Clk;

   function automatic sprite_word_t rom_fn(input sprite_addr_t a);
      return {a, 2'b10, a} ^ 32'hC3A5_0F1E;
   endfunction

   // ROM with LAT-1 internal register: word for rom_addr appears one clock later.
   always @(posedge Clk) rom_data <= rom_fn(rom_addr);

   typedef struct {
      int           id;
      sprite_addr_t addr;
      int           due;
   } rsp_t;

   rsp_t         exp_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           cyc = 0;
   int           m_ptr = 0;
   sprite_addr_t m_rom_addr = '0;
   bit           m_known = 1'b0;
   bit           post_rst = 1'b0;
   logic [N-1:0] last_gnt = '0;

   logic         drv_rst = 1'b1;
   logic [N-1:0] drv_req = '0;
   logic [N*AW-1:0] drv_addr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      else
         n_pass++;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef SPRITE_ARB_PRIO0_EN
      int base;
      if (r[0]) return 0;
      base = (ptr == 0) ? 0 : ptr - 1;
      for (int k = 0; k < int'(N) - 1; k++) begin
         int i = 1 + (base + k) % (int'(N) - 1);
         if (r[i]) return i;
      end
`else
      for (int k = 0; k < int'(N); k++) begin
         int i = (ptr + k) % int'(N);
         if (r[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic int next_ptr(input int w, input int ptr);
`ifdef SPRITE_ARB_PRIO0_EN
      return (w == 0) ? ptr : 1 + (w % (int'(N) - 1));
`else
      return (w + 1) % int'(N);
`endif
   endfunction

   task automatic set_addr(input int i, input sprite_addr_t a);
      drv_addr[i*AW +: AW] = a;
   endtask

   task automatic tick();
      int           w;
      logic [N-1:0] eg;
      bit           exp_v;
      @(negedge Clk);
      Reset    = drv_rst;
      req      = drv_req;
      req_addr = drv_addr;
      #1;
      w  = drv_rst ? -1 : pick(drv_req, m_ptr);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      check("gnt", 64'(gnt), 64'(eg));
      if (m_known) begin
         check("rom_addr", 64'(rom_addr), 64'(m_rom_addr));
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("rd_valid", 64'(rd_valid), 64'(exp_v));
         if (exp_v) begin
            check("rd_id", 64'(rd_id), 64'(exp_q[0].id));
            check("rd_data", 64'(rd_data), 64'(rom_fn(exp_q[0].addr)));
            void'(exp_q.pop_front());
         end
         if (post_rst) begin
            check("rst_rd_id", 64'(rd_id), 64'd0);
            check("rst_rd_data", 64'(rd_data), 64'd0);
         end
      end
      post_rst = 1'b0;
      if (drv_rst) begin
         m_known    = 1'b1;
         m_ptr      = 0;
         m_rom_addr = '0;
         exp_q.delete();
         post_rst   = 1'b1;
      end else if (w >= 0) begin
         m_rom_addr = drv_addr[w*AW +: AW];
         exp_q.push_back('{w, drv_addr[w*AW +: AW], cyc + int'(LAT) + 1});
         m_ptr = next_ptr(w, m_ptr);
      end
      last_gnt = eg;
      cyc++;
   endtask

   task automatic idle(input int n);
      drv_rst = 1'b0;
      drv_req = '0;
      for (int k = 0; k < n; k++) tick();
   endtask

   logic [N-1:0] pend;

   initial begin
      // Reset held 3 clocks with every client requesting.
      drv_rst = 1'b1;
      drv_req = '1;
      for (int i = 0; i < int'(N); i++) set_addr(i, sprite_addr_t'(100 + i));
      repeat (3) tick();

      // Single read from client 1.
      drv_rst = 1'b0;
      drv_req = 4'b0010;
      set_addr(1, 15'd139);
      tick();
      idle(4);

      // Fairness: all clients held for 8 cycles, then drain.
      drv_rst = 1'b1; drv_req = '0; tick();
      drv_rst = 1'b0;
      drv_req = '1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < int'(N); i++) set_addr(i, sprite_addr_t'(1000 + 16*k + i));
         tick();
      end
      idle(4);

      // Wrap/skip: park pointer at 3, then 0 and 2 compete.
      drv_rst = 1'b1; tick();
      drv_rst = 1'b0;
      drv_req = 4'b0100; set_addr(2, 15'd222); tick();
      drv_req = 4'b0101; set_addr(0, 15'd300); set_addr(2, 15'd302); tick();
      drv_req = 4'b0100; tick();
      drv_req = 4'b1001; set_addr(3, 15'd333); set_addr(0, 15'd301); tick();
      idle(4);

      // Mid-flight reset drops the outstanding read.
      drv_req = 4'b0001; set_addr(0, 15'd140); tick();
      drv_req = '0; drv_rst = 1'b1; tick();
      idle(4);

`ifdef SPRITE_ARB_PRIO0_EN
      drv_req = 4'b1111;
      repeat (4) tick();
      drv_req = 4'b1110;
      repeat (4) tick();
      idle(4);
`endif

      // Randomized clients: hold until granted, occasional drops and resets.
      pend = '0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (pend[i] && last_gnt[i]) pend[i] = 1'b0;
            if (pend[i] && $urandom_range(0, 31) == 0) begin
               pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               set_addr(i, sprite_addr_t'($urandom));
            end
         end
         drv_req = pend;
         drv_rst = ($urandom_range(0, 149) == 0);
         if (drv_rst) pend = '0;
         tick();
      end
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
